gpr_file_px: RTL and testbench
==============================

Name: gpr_file_px

Overview:
- Parametrised successor to the 32x8 general-purpose register file.
- Adds a 16-bit register-pair write port (MOVW/ADIW-style) and a register-pair read port.
- Adds an X/Y/Z pointer unit with post-increment, pre-decrement and displacement addressing.
- Adds optional write-to-read bypass and a multi-cycle clear-sweep FSM. Sits between the decoder/ALU writeback and the load/store address path.

Parameters:
DATA_W, 8, register width in bits
DEPTH, 32, number of registers; even, >= 8
ADDR_W, 5, register address width = clog2(DEPTH)
RESET_INDEX, 1, 1: reset loads reg[i] = i mod 2^DATA_W; 0: reset loads 0
BYPASS, 1, 1: same-cycle writes forwarded to read ports; 0: reads return stored value
PTR_BASE, 26, index of X low byte; Y = PTR_BASE+2, Z = PTR_BASE+4; PTR_BASE+5 < DEPTH

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
we  in  1  byte write enable
waddr  in  ADDR_W  byte write address
wdata  in  DATA_W  byte write data
pwe  in  1  pair write enable
paddr  in  ADDR_W  pair write address; bit 0 ignored (forced even)
pwdata  in  2*DATA_W  pair data: low byte -> reg[paddr], high byte -> reg[paddr+1]
raddr1 / raddr2  in  ADDR_W  read addresses
rdata1 / rdata2  out  DATA_W  read data, combinational
praddr  in  ADDR_W  pair read address; bit 0 ignored
prdata  out  2*DATA_W  {reg[praddr+1], reg[praddr]}, combinational
ptr_en  in  1  pointer operation valid this cycle
ptr_sel  in  2  0 = X, 1 = Y, 2 = Z, 3 = reserved (no-op, ptr_ea = 0)
ptr_mode  in  2  00 plain, 01 post-inc, 10 pre-dec, 11 displacement
ptr_disp  in  6  unsigned displacement (mode 11 only)
ptr_ea  out  2*DATA_W  effective address, combinational
clr_req  in  1  request clear sweep
busy  out  1  sweep in progress

Behaviour:
- Reset: the entire file loads per RESET_INDEX; FSM goes to IDLE; busy = 0. Reset is synchronous and overrides every other input in that cycle, including mid-sweep.
- Writes commit on the rising clk edge. Reads are combinational; read latency is 0.
- Pointer P is {reg[b+1], reg[b]} with b = PTR_BASE + 2*ptr_sel. ptr_ea is always computed from stored contents, never bypassed.
  - Mode 00: ea = P; no update.
  - Mode 01: ea = P; P <= P + 1.
  - Mode 10: ea = P - 1; P <= P - 1.
  - Mode 11: ea = P + zero-extended ptr_disp; no update.
  - All arithmetic wraps modulo 2^(2*DATA_W). ptr_ea is only meaningful while ptr_en = 1.
- Same-register collisions in one cycle are resolved per byte: pointer update > pair write > byte write. The losing write to that byte is dropped; non-colliding bytes still commit.
- BYPASS = 1: rdata1, rdata2 and prdata return the winning pending write value for each addressed byte, combinationally, in the same cycle.
- BYPASS = 0: read ports return stored values; new data is visible the cycle after the edge.
- FSM states:
  - IDLE: clr_req = 1 -> CLEAR with cnt = 0; busy goes high from the next cycle.
  - CLEAR: reg[cnt] <= 0 each cycle; cnt increments; after cnt = DEPTH-1 -> IDLE, busy = 0.
  - Total duration is DEPTH cycles.
- While busy: we, pwe and pointer updates are ignored (no commit, no bypass). ptr_ea is still driven. clr_req is ignored. Reads return current stored contents, already-cleared entries read 0.
- Simultaneous clr_req with writes in IDLE: the writes commit in that cycle; the sweep then clears them.
- Out-of-range addresses (>= DEPTH, when DEPTH < 2^ADDR_W): writes are dropped and reads return 0.

Decomposition:
- Package gpr_px_pkg holds:
  - PTR_X/PTR_Y/PTR_Z select codes
  - PM_PLAIN/PM_POSTINC/PM_PREDEC/PM_DISP mode codes
  - FSM state encoding ST_IDLE/ST_CLEAR
- Sub-module gpr_ptr_unit: purely combinational. Computes ptr_ea, the next pointer value and the update-enable from P, ptr_mode and ptr_disp; parametrised on DATA_W.

Test Plan:
- Reset with RESET_INDEX = 1: raddr1 = 5, raddr2 = 31 -> rdata1 = 8'h05, rdata2 = 8'h1F; praddr = 26 -> prdata = 16'h1B1A; busy = 0.
- Z = 16'h00FF (reg30 = FF, reg31 = 00), ptr_en with sel = 2, mode 01 -> ptr_ea = 16'h00FF; next cycle prdata at 30 = 16'h0100. Then mode 10 -> ptr_ea = 16'h00FF. X = 0000 with mode 10 -> ptr_ea = 16'hFFFF.
- Y = 16'h1000, mode 11, disp = 63 -> ptr_ea = 16'h103F, Y unchanged. Then pwe paddr = 29 (forced to 28) with pwdata = 16'hBEEF -> reg28 = EF, reg29 = BE.
- BYPASS = 1: same cycle we to addr 3 = 8'hAA and raddr1 = 3 -> rdata1 = AA in that cycle. Collision we addr 26 = 11, pwe 26 = 2233, ptr post-inc on X = 00FF -> reg26 = 00, reg27 = 01.
- clr_req in IDLE -> busy high exactly 32 cycles; a we issued mid-sweep is ignored; afterwards every register reads 0.
- rst asserted at sweep cycle 10 -> next cycle busy = 0, reg[20] = 8'h14, reg[3] = 8'h03.

Source files
------------

// File: rtl/gpr_px_pkg.sv
// Shared encodings for the register file with pointer unit.
//   PTR_X/PTR_Y/PTR_Z      : pointer select codes (3 is reserved)
//   PM_*                   : pointer addressing mode codes
//   state_t                : clear-sweep FSM state encoding
package gpr_px_pkg;

    localparam logic [1:0] PTR_X = 2'd0;
    localparam logic [1:0] PTR_Y = 2'd1;
    localparam logic [1:0] PTR_Z = 2'd2;

    localparam logic [1:0] PM_PLAIN   = 2'b00;
    localparam logic [1:0] PM_POSTINC = 2'b01;
    localparam logic [1:0] PM_PREDEC  = 2'b10;
    localparam logic [1:0] PM_DISP    = 2'b11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/gpr_ptr_unit.sv
// Combinational pointer arithmetic for X/Y/Z addressing.
//   ptr_val  in  : current 16-bit (2*DATA_W) pointer contents
//   ptr_mode in  : plain / post-inc / pre-dec / displacement
//   ptr_disp in  : unsigned 6-bit displacement (displacement mode only)
//   ptr_ea   out : effective address
//   ptr_nxt  out : value to write back into the pointer pair
//   ptr_upd  out : pointer pair must be written back this cycle
module gpr_ptr_unit
    import gpr_px_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2*DATA_W-1:0] ptr_val,
    input  logic [1:0]          ptr_mode,
    input  logic [5:0]          ptr_disp,
    output logic [2*DATA_W-1:0] ptr_ea,
    output logic [2*DATA_W-1:0] ptr_nxt,
    output logic                ptr_upd
);

    localparam int PW = 2 * DATA_W;

    // All arithmetic wraps naturally at PW bits.
    always_comb begin
        ptr_ea  = ptr_val;
        ptr_nxt = ptr_val;
        ptr_upd = 1'b0;
        case (ptr_mode)
            PM_POSTINC: begin
                ptr_nxt = ptr_val + PW'(1);
                ptr_upd = 1'b1;
            end
            PM_PREDEC: begin
                ptr_ea  = ptr_val - PW'(1);
                ptr_nxt = ptr_val - PW'(1);
                ptr_upd = 1'b1;
            end
            PM_DISP: begin
                ptr_ea = ptr_val + PW'(ptr_disp);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/gpr_file_px.sv
// General-purpose register file with byte and pair write ports, two byte
// read ports, one pair read port, an X/Y/Z pointer unit and a clear sweep.
//   clk, rst            : clock, synchronous active-high reset
//   we/waddr/wdata      : byte write
//   pwe/paddr/pwdata    : pair write (paddr bit 0 ignored)
//   raddr1/2, rdata1/2  : combinational byte reads
//   praddr, prdata      : combinational pair read (praddr bit 0 ignored)
//   ptr_en/sel/mode/disp: pointer operation, ptr_ea effective address
//   clr_req, busy       : start clear sweep / sweep in progress
module gpr_file_px
    import gpr_px_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 5,
    parameter int RESET_INDEX = 1,
    parameter int BYPASS      = 1,
    parameter int PTR_BASE    = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                pwe,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [2*DATA_W-1:0] pwdata,
    input  logic [ADDR_W-1:0]   raddr1,
    input  logic [ADDR_W-1:0]   raddr2,
    output logic [DATA_W-1:0]   rdata1,
    output logic [DATA_W-1:0]   rdata2,
    input  logic [ADDR_W-1:0]   praddr,
    output logic [2*DATA_W-1:0] prdata,
    input  logic                ptr_en,
    input  logic [1:0]          ptr_sel,
    input  logic [1:0]          ptr_mode,
    input  logic [5:0]          ptr_disp,
    output logic [2*DATA_W-1:0] ptr_ea,
    input  logic                clr_req,
    output logic                busy
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] X_LO    = ADDR_W'(PTR_BASE);
    localparam logic [ADDR_W-1:0] Y_LO    = ADDR_W'(PTR_BASE + 2);
    localparam logic [ADDR_W-1:0] Z_LO    = ADDR_W'(PTR_BASE + 4);

    logic [DATA_W-1:0]   mem [DEPTH];
    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt;

    logic [ADDR_W-1:0]   ptr_lo, ptr_hi;
    logic                ptr_ok;
    logic [2*DATA_W-1:0] ptr_val, ptr_ea_raw, ptr_nxt;
    logic                ptr_upd;

    logic [ADDR_W-1:0]   pa_lo, pa_hi;
    logic                wen  [DEPTH];
    logic [DATA_W-1:0]   wval [DEPTH];

    // Pair addresses are forced even; bit 0 is intentionally discarded.
    logic unused_bits;
    assign unused_bits = ^{paddr[0], praddr[0]};

    assign busy  = (state == ST_CLEAR);
    assign pa_lo = {paddr[ADDR_W-1:1], 1'b0};
    assign pa_hi = {paddr[ADDR_W-1:1], 1'b1};

    // Pointer selection; the reserved select reads as a no-op with ea = 0.
    always_comb begin
        ptr_ok = 1'b1;
        ptr_lo = X_LO;
        case (ptr_sel)
            PTR_X:   ptr_lo = X_LO;
            PTR_Y:   ptr_lo = Y_LO;
            PTR_Z:   ptr_lo = Z_LO;
            default: ptr_ok = 1'b0;
        endcase
        ptr_hi  = ptr_lo + ADDR_W'(1);
        ptr_val = {mem[ptr_hi], mem[ptr_lo]};
    end

    gpr_ptr_unit #(
        .DATA_W   (DATA_W)
    ) u_ptr (
        .ptr_val  (ptr_val),
        .ptr_mode (ptr_mode),
        .ptr_disp (ptr_disp),
        .ptr_ea   (ptr_ea_raw),
        .ptr_nxt  (ptr_nxt),
        .ptr_upd  (ptr_upd)
    );

    assign ptr_ea = ptr_ok ? ptr_ea_raw : '0;

    // Per-byte write arbitration. Later assignments win, giving
    // pointer update > pair write > byte write. Only in-range indices
    // exist here, so out-of-range writes fall away on their own.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wen[i]  = 1'b0;
            wval[i] = '0;
            if (we && waddr == ADDR_W'(i)) begin
                wen[i]  = 1'b1;
                wval[i] = wdata;
            end
            if (pwe && pa_lo == ADDR_W'(i)) begin
                wen[i]  = 1'b1;
                wval[i] = pwdata[DATA_W-1:0];
            end
            if (pwe && pa_hi == ADDR_W'(i)) begin
                wen[i]  = 1'b1;
                wval[i] = pwdata[2*DATA_W-1:DATA_W];
            end
            if (ptr_en && ptr_ok && ptr_upd && ptr_lo == ADDR_W'(i)) begin
                wen[i]  = 1'b1;
                wval[i] = ptr_nxt[DATA_W-1:0];
            end
            if (ptr_en && ptr_ok && ptr_upd && ptr_hi == ADDR_W'(i)) begin
                wen[i]  = 1'b1;
                wval[i] = ptr_nxt[2*DATA_W-1:DATA_W];
            end
            if (busy) begin
                wen[i] = 1'b0;
            end
        end
    end

    function automatic logic [DATA_W-1:0] rd_byte(input logic [ADDR_W-1:0] a);
        if ({1'b0, a} >= DEPTH_L) return '0;
        if (BYPASS != 0 && wen[a]) return wval[a];
        return mem[a];
    endfunction

    always_comb begin
        rdata1 = rd_byte(raddr1);
        rdata2 = rd_byte(raddr2);
        prdata = {rd_byte({praddr[ADDR_W-1:1], 1'b1}),
                  rd_byte({praddr[ADDR_W-1:1], 1'b0})};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clr_req) state_nxt = ST_CLEAR;
            ST_CLEAR: if (cnt == LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ST_CLEAR) ? cnt + ADDR_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (RESET_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else if (state == ST_CLEAR) begin
            mem[cnt] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wen[i]) mem[i] <= wval[i];
            end
        end
    end

endmodule

// File: tb/tb_gpr_file_px.sv
module tb_gpr_file_px;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [7:0]  wdata;
    logic        pwe;
    logic [4:0]  paddr;
    logic [15:0] pwdata;
    logic [4:0]  raddr1, raddr2, praddr;
    logic [7:0]  rdata1, rdata2;
    logic [15:0] prdata;
    logic        ptr_en;
    logic [1:0]  ptr_sel, ptr_mode;
    logic [5:0]  ptr_disp;
    logic [15:0] ptr_ea;
    logic        clr_req;
    logic        busy;

    gpr_file_px dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .pwe(pwe), .paddr(paddr), .pwdata(pwdata),
        .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1), .rdata2(rdata2),
        .praddr(praddr), .prdata(prdata),
        .ptr_en(ptr_en), .ptr_sel(ptr_sel), .ptr_mode(ptr_mode),
        .ptr_disp(ptr_disp), .ptr_ea(ptr_ea),
        .clr_req(clr_req), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: register contents as plain integers plus sweep progress.
    int m_mem [32];
    bit m_busy;
    int m_cnt;
    bit pv [32];
    int pd [32];

    function automatic int ptr_of(input int sel);
        int b = 26 + 2 * sel;
        return m_mem[b+1] * 256 + m_mem[b];
    endfunction

    // Writes requested this cycle; later rules override earlier ones on a byte.
    task automatic compute_pending();
        for (int i = 0; i < 32; i++) begin pv[i] = 0; pd[i] = 0; end
        if (m_busy) return;
        if (we) begin pv[waddr] = 1; pd[waddr] = wdata; end
        if (pwe) begin
            int a = paddr & 30;
            pv[a] = 1;   pd[a]   = pwdata & 255;
            pv[a+1] = 1; pd[a+1] = pwdata >> 8;
        end
        if (ptr_en && ptr_sel != 3 && (ptr_mode == 1 || ptr_mode == 2)) begin
            int b  = 26 + 2 * ptr_sel;
            int np = (ptr_mode == 1) ? (ptr_of(ptr_sel) + 1) % 65536
                                     : (ptr_of(ptr_sel) + 65535) % 65536;
            pv[b] = 1;   pd[b]   = np % 256;
            pv[b+1] = 1; pd[b+1] = np / 256;
        end
    endtask

    function automatic int exp_rd(input int a);
        return pv[a] ? pd[a] : m_mem[a];
    endfunction

    function automatic int exp_ea();
        int p;
        if (ptr_sel == 3) return 0;
        p = ptr_of(ptr_sel);
        case (ptr_mode)
            2'd2:    return (p + 65535) % 65536;
            2'd3:    return (p + ptr_disp) % 65536;
            default: return p;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = i;
        m_busy = 0;
        m_cnt  = 0;
    endtask

    // One clock: check combinational outputs mid-cycle, then advance model.
    task automatic step();
        int pa;
        @(negedge clk);
        compute_pending();
        if (!rst) begin
            pa = praddr & 30;
            chk("rdata1", rdata1, exp_rd(raddr1));
            chk("rdata2", rdata2, exp_rd(raddr2));
            chk("prdata", prdata, exp_rd(pa + 1) * 256 + exp_rd(pa));
            if (ptr_en) chk("ptr_ea", ptr_ea, exp_ea());
            chk("busy", busy, m_busy);
        end
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            m_mem[m_cnt] = 0;
            m_cnt++;
            if (m_cnt == 32) m_busy = 0;
        end else begin
            for (int i = 0; i < 32; i++) if (pv[i]) m_mem[i] = pd[i];
            if (clr_req) begin m_busy = 1; m_cnt = 0; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; we = 0; pwe = 0; ptr_en = 0; clr_req = 0;
        waddr = 0; wdata = 0; paddr = 0; pwdata = 0;
        ptr_sel = 0; ptr_mode = 0; ptr_disp = 0;
    endtask

    initial begin
        int busy_cycles;
        idle_inputs();
        raddr1 = 0; raddr2 = 0; praddr = 0;
        m_busy = 0; m_cnt = 0;
        for (int i = 0; i < 32; i++) m_mem[i] = 0;

        // Reset values
        rst = 1; step(); rst = 0;
        raddr1 = 5; raddr2 = 31; praddr = 26;
        #2;
        chk("rst_r5", rdata1, 8'h05);
        chk("rst_r31", rdata2, 8'h1F);
        chk("rst_p26", prdata, 16'h1B1A);
        chk("rst_busy", busy, 0);
        step();

        // Z post-inc across byte boundary, then pre-dec
        pwe = 1; paddr = 30; pwdata = 16'h00FF; step(); pwe = 0;
        ptr_en = 1; ptr_sel = 2; ptr_mode = 2'b01;
        #2; chk("z_postinc_ea", ptr_ea, 16'h00FF); step();
        ptr_en = 0; praddr = 30;
        #2; chk("z_after_inc", prdata, 16'h0100); step();
        ptr_en = 1; ptr_sel = 2; ptr_mode = 2'b10;
        #2; chk("z_predec_ea", ptr_ea, 16'h00FF); step();
        ptr_en = 0;
        // X pre-dec wraps below zero
        pwe = 1; paddr = 26; pwdata = 16'h0000; step(); pwe = 0;
        ptr_en = 1; ptr_sel = 0; ptr_mode = 2'b10;
        #2; chk("x_predec_wrap", ptr_ea, 16'hFFFF); step();
        ptr_en = 0;

        // Y displacement, then odd pair address forced even
        pwe = 1; paddr = 28; pwdata = 16'h1000; step(); pwe = 0;
        ptr_en = 1; ptr_sel = 1; ptr_mode = 2'b11; ptr_disp = 63;
        #2; chk("y_disp_ea", ptr_ea, 16'h103F); step();
        ptr_en = 0; praddr = 28;
        #2; chk("y_unchanged", prdata, 16'h1000); step();
        pwe = 1; paddr = 29; pwdata = 16'hBEEF; step(); pwe = 0;
        raddr1 = 28; raddr2 = 29;
        #2; chk("pair_lo", rdata1, 8'hEF); chk("pair_hi", rdata2, 8'hBE); step();

        // Same-cycle bypass
        we = 1; waddr = 3; wdata = 8'hAA; raddr1 = 3;
        #2; chk("bypass", rdata1, 8'hAA); step(); we = 0;

        // Three-way collision on X
        pwe = 1; paddr = 26; pwdata = 16'h00FF; step();
        we = 1; waddr = 26; wdata = 8'h11; pwdata = 16'h2233;
        ptr_en = 1; ptr_sel = 0; ptr_mode = 2'b01;
        step();
        idle_inputs(); raddr1 = 26; raddr2 = 27;
        #2; chk("coll_r26", rdata1, 8'h00); chk("coll_r27", rdata2, 8'h01); step();

        // Clear sweep with an ignored mid-sweep write
        clr_req = 1; step(); clr_req = 0;
        raddr1 = 0;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            we = (i == 5); waddr = 0; wdata = 8'h55;
            #2; if (busy) busy_cycles++;
            step();
        end
        we = 0;
        chk("busy_len", busy_cycles, 32);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); #1;
            chk("cleared", rdata1, 0);
        end
        @(posedge clk); #1;

        // Reset mid-sweep
        clr_req = 1; step(); clr_req = 0;
        for (int i = 0; i < 10; i++) step();
        rst = 1; step(); rst = 0;
        raddr1 = 20; raddr2 = 3;
        #2;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_r20", rdata1, 8'h14);
        chk("rst_mid_r3", rdata2, 8'h03);
        step();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 199) == 0);
            we       = $urandom_range(0, 1);
            waddr    = 5'($urandom);
            wdata    = 8'($urandom);
            pwe      = ($urandom_range(0, 2) == 0);
            paddr    = 5'($urandom_range(0, 1) ? $urandom_range(24, 31) : $urandom);
            pwdata   = 16'($urandom);
            ptr_en   = $urandom_range(0, 1);
            ptr_sel  = 2'($urandom);
            ptr_mode = 2'($urandom);
            ptr_disp = 6'($urandom);
            clr_req  = ($urandom_range(0, 79) == 0);
            raddr1   = 5'($urandom_range(0, 1) ? $urandom_range(24, 31) : $urandom);
            raddr2   = 5'($urandom);
            praddr   = 5'($urandom_range(0, 1) ? $urandom_range(24, 31) : $urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
